// File: rtl/rtc_gen_pkg.sv
// rtc_gen_pkg: shared types and constants for the rtc_gen stream kernel.
// Contents: burst_tx_state_t, the burst source FSM states, plus zero and one
// constants for beat-count comparisons. Modules cast these constants to their
// own count width.
package rtc_gen_pkg;
  typedef enum logic [1:0] {IDLE, SEND, DONE} burst_tx_state_t;
  localparam int LEN_W = 16;
  localparam logic [LEN_W-1:0] LEN_ZERO = '0;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
endpackage

// File: rtl/rtc_gen_down_counter.sv
// rtc_gen_down_counter: load/decrement counter that flags a count of one.
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   load_i         loads load_val_i; takes priority over dec_i
//   dec_i          decrements the count by one
//   is_one_o       high while the held count equals one
module rtc_gen_down_counter import rtc_gen_pkg::*; #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         is_one_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : dec_i ? cnt_q - W'(LEN_ONE) : cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign is_one_o = cnt_q == W'(LEN_ONE);
endmodule

// File: rtl/rtc_gen_axis_burst_tx.sv
// rtc_gen_axis_burst_tx: AXI4-Stream burst source.
// Behaviour: each accepted command produces cmd_len beats of incrementing
// data, starting at cmd_start. TLAST marks the final beat, and done pulses
// once after the burst ends.
// Ports:
//   ap_clk, ap_rst_n                           clock and asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_len, cmd_start    command handshake and payload
//   m_axis_tvalid/tready/tdata/tlast           outgoing stream
//   done                                       one-cycle end-of-burst pulse
// Build option: RTC_GEN_BURST_TX_STATS_EN adds two outputs.
//   stat_beats   transfer count
//   stat_bursts  done-pulse count
module rtc_gen_axis_burst_tx import rtc_gen_pkg::*; #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_LEN_WIDTH  = 16
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [C_LEN_WIDTH-1:0]  cmd_len,
  input  logic [C_DATA_WIDTH-1:0] cmd_start,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic                    done
`ifdef RTC_GEN_BURST_TX_STATS_EN
  ,
  output logic [31:0]             stat_beats,
  output logic [15:0]             stat_bursts
`endif
);
  burst_tx_state_t state_q, state_d;
  logic [C_DATA_WIDTH-1:0] data_q, data_d;
  logic live_q, rem_is_one, accept, xfer;
  // The state register resets to IDLE, but cmd_ready must stay low until the
  // first clock after reset release. live_q provides that delay.
  assign cmd_ready     = live_q && state_q == IDLE;
  assign m_axis_tvalid = state_q == SEND;
  assign m_axis_tlast  = m_axis_tvalid && rem_is_one;
  assign m_axis_tdata  = data_q;
  assign done          = state_q == DONE;
  assign accept        = cmd_valid && cmd_ready;
  assign xfer          = m_axis_tvalid && m_axis_tready;
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (accept) state_d = cmd_len == C_LEN_WIDTH'(LEN_ZERO) ? DONE : SEND;
    else if (state_q == SEND && xfer && rem_is_one) state_d = DONE;
    else if (state_q == DONE) state_d = IDLE;
    data_d = accept ? cmd_start : xfer ? data_q + C_DATA_WIDTH'(1) : data_q;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      live_q  <= 1'b1;
    end
  rtc_gen_down_counter #(.W(C_LEN_WIDTH)) u_remaining (
    .clk_i      (ap_clk),
    .rst_ni     (ap_rst_n),
    .load_i     (accept),
    .dec_i      (xfer),
    .load_val_i (cmd_len),
    .is_one_o   (rem_is_one)
  );
`ifdef RTC_GEN_BURST_TX_STATS_EN
  logic [31:0] beats_q;
  logic [15:0] bursts_q;
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      beats_q  <= '0;
      bursts_q <= '0;
    end else begin
      beats_q  <= beats_q + 32'(xfer);
      bursts_q <= bursts_q + 16'(done);
    end
  assign stat_beats  = beats_q;
  assign stat_bursts = bursts_q;
`endif
endmodule

// File: tb/tb_rtc_gen_axis_burst_tx.sv
// tb_rtc_gen_axis_burst_tx: randomized self-checking bench for the burst source
module tb_rtc_gen_axis_burst_tx;
  logic ap_clk = 1'b0, ap_rst_n = 1'b1, cmd_valid = 1'b0, m_axis_tready = 1'b0;
  logic cmd_ready, m_axis_tvalid, m_axis_tlast, done;
  logic [15:0] cmd_len = '0;
  logic [31:0] cmd_start = '0;
  logic [31:0] m_axis_tdata;
  int total = 0, bad = 0;
  int m_beats = 0, m_bursts = 0;
`ifdef RTC_GEN_BURST_TX_STATS_EN
  logic [31:0] stat_beats;
  logic [15:0] stat_bursts;
`endif
  always #5 ap_clk = ~ap_clk;
  rtc_gen_axis_burst_tx #(.C_DATA_WIDTH(32), .C_LEN_WIDTH(16)) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_len       (cmd_len),
    .cmd_start     (cmd_start),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .done          (done)
`ifdef RTC_GEN_BURST_TX_STATS_EN
    ,
    .stat_beats    (stat_beats),
    .stat_bursts   (stat_bursts)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask
  // Reference model: a burst is the list start, start+1, ... (mod 2^32).
  // Each beat is shown until the sink takes it. done follows the last
  // transfer, and cmd_ready returns one cycle later. The caller arrives one
  // step after an edge with the block idle.
  task automatic run_burst(input int len, input logic [31:0] start, input int pct, input bit hold);
    logic [31:0] q[$];
    bit fire;
    int guard = 0;
    for (int i = 0; i < len; i++) q.push_back(start + 32'(i));
    chk("idle_ready", cmd_ready, 1);
    chk("idle_tvalid", m_axis_tvalid, 0);
    cmd_len = 16'(len);
    cmd_start = start;
    cmd_valid = 1'b1;
    tick();
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_len = 16'($urandom);
      cmd_start = $urandom;
    end
    while (q.size() > 0 && guard < 500) begin
      chk("tvalid", m_axis_tvalid, 1);
      chk("tdata", m_axis_tdata, q[0]);
      chk("tlast", m_axis_tlast, q.size() == 1);
      chk("busy_done", done, 0);
      chk("busy_ready", cmd_ready, 0);
      m_axis_tready = $urandom_range(99) < pct;
      fire = m_axis_tready;
      tick();
      if (fire) void'(q.pop_front());
      guard++;
    end
    chk("beats_left", q.size(), 0);
    m_beats += len;
    m_axis_tready = 1'($urandom);
    chk("done_pulse", done, 1);
    chk("done_tvalid", m_axis_tvalid, 0);
    chk("done_tlast", m_axis_tlast, 0);
    chk("done_ready", cmd_ready, 0);
    m_bursts++;
    tick();
    chk("done_clear", done, 0);
    chk("ready_back", cmd_ready, 1);
    chk("after_tvalid", m_axis_tvalid, 0);
  endtask
  task automatic check_stats();
`ifdef RTC_GEN_BURST_TX_STATS_EN
    chk("stat_beats", stat_beats, 32'(m_beats));
    chk("stat_bursts", stat_bursts, 16'(m_bursts));
`endif
  endtask
  initial begin
    #2 ap_rst_n = 1'b0;
    #1;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_done", done, 0);
    check_stats();
    repeat (2) tick();
    ap_rst_n = 1'b1;
    chk("rel_ready_low", cmd_ready, 0);
    tick();
    chk("rel_ready_high", cmd_ready, 1);
    run_burst(4, 32'h10, 100, 0);
    run_burst(0, $urandom, 100, 0);
    run_burst(3, 32'hFFFF_FFFF, 50, 0);
    run_burst(2, 32'h200, 100, 1);
    run_burst(2, 32'h300, 100, 0);
    check_stats();
    cmd_len = 16'd5;
    cmd_start = 32'h100;
    cmd_valid = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("mid_tdata", m_axis_tdata, 32'h100 + 32'(i));
      chk("mid_tlast", m_axis_tlast, 0);
      tick();
    end
    #2 ap_rst_n = 1'b0;
    #1;
    m_beats = 0;
    m_bursts = 0;
    chk("mid_rst_tvalid", m_axis_tvalid, 0);
    chk("mid_rst_tlast", m_axis_tlast, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    check_stats();
    repeat (2) begin
      tick();
      chk("mid_rst_no_done", done, 0);
    end
    ap_rst_n = 1'b1;
    tick();
    chk("mid_rel_ready", cmd_ready, 1);
    chk("mid_rel_done", done, 0);
    run_burst(1, 32'hABCD, 100, 0);
    run_burst(4, $urandom, 100, 0);
    run_burst(0, $urandom, 100, 0);
    run_burst(3, $urandom, 70, 0);
    check_stats();
    for (int n = 0; n < 30; n++) begin
      int sel;
      sel = $urandom_range(2);
      run_burst($urandom_range(7), ($urandom_range(3) == 0) ? 32'hFFFF_FFFE : $urandom,
                sel == 0 ? 100 : sel == 1 ? 50 : 25, 1'($urandom));
    end
    check_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rtc_gen_axis_burst_tx.md
# rtc_gen_axis_burst_tx

AXI4-Stream burst source for the rtc_gen stream kernel. It accepts a command holding a beat count and a start value, then emits that many beats of incrementing data with TLAST on the final beat. It pulses `done` when the burst ends. It is the transmit-side counterpart of the kernel's beat and occupancy counters: those count beats in, this block generates beats out. It sits between the kernel control logic and the outgoing AXI4-Stream port.

## Interface
Parameters:
- `C_DATA_WIDTH`, 32: TDATA width in bits (multiple of 8, 8..512).
- `C_LEN_WIDTH`, 16: width of the beat-count field. Maximum burst is 2^C_LEN_WIDTH−1 beats.

Ports:
- `ap_clk`  in  1  single clock, rising edge.
- `ap_rst_n`  in  1  asynchronous reset, active-low. Assertion is asynchronous; release is sampled on `ap_clk`.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_len`  in  C_LEN_WIDTH  number of beats to send (0 is allowed).
- `cmd_start`  in  C_DATA_WIDTH  TDATA value of the first beat.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  sink ready.
- `m_axis_tdata`  out  C_DATA_WIDTH  beat payload.
- `m_axis_tlast`  out  1  final beat of the burst.
- `done`  out  1  one-cycle pulse at the end of the burst.

## Operation
- The state machine has three states: IDLE, SEND, DONE.
- **IDLE:** `cmd_ready`=1. On accept, the block latches `cmd_len` into the remaining-beat counter and `cmd_start` into the data register.
  - If `cmd_len`≠0, the next state is SEND.
  - If `cmd_len`=0, the next state is DONE and no beat is sent.
- **SEND:** `m_axis_tvalid`=1.
  - `m_axis_tlast` = (remaining == 1).
  - On each transfer (`tvalid`&&`tready`), remaining decrements by 1 and data increments by 1.
  - The transfer with `tlast`=1 moves the state to DONE.
- **DONE:** `done`=1 for exactly one cycle, then the state returns to IDLE.
- Data arithmetic is modulo 2^C_DATA_WIDTH. For example, with width 32 a start of 0xFFFF_FFFF gives beats 0xFFFF_FFFF, 0x0000_0000, and so on.
- Stall rule: while `tvalid`=1 and `tready`=0, `tdata`, `tlast` and `tvalid` hold stable. Once `tvalid` is asserted it does not drop before a transfer.
- `cmd_ready`=0 in SEND and DONE. Commands offered in those states wait and are not lost.
- Reset mid-burst: all state is cleared immediately. The burst is abandoned with no TLAST and no `done`.

## Timing
- Reset values:
  - `cmd_ready`=0 while `ap_rst_n`=0, then 1 from the first clock after release (IDLE).
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `done`=0.
- A command accepted at edge N gives `tvalid`=1 in the cycle after N (one cycle of latency).
- With `tready` held at 1, an L-beat burst transfers on L consecutive cycles.
- The `done` pulse falls in the cycle after the last transfer.
- `cmd_ready` returns to 1 in the cycle after `done`. The minimum command-to-command period is L+2 cycles for L≥1, and 2 cycles for L=0.
- All outputs are registered. There is no combinational path from `m_axis_tready` or `cmd_valid` to any output.

## Configuration
- The macro is `RTC_GEN_BURST_TX_STATS_EN`.
- **Defined:** adds two outputs.
  - `stat_beats` (out, 32): counts every AXIS transfer, wraps at 2^32.
  - `stat_bursts` (out, 16): counts every `done` pulse, wraps at 2^16.
  - Both reset to 0 on `ap_rst_n`.
- **Undefined:** the ports and counters are absent, and the behaviour is otherwise identical.

## Structure
- Shared package `rtc_gen_pkg` holds:
  - the state enum `burst_tx_state_t` (IDLE, SEND, DONE);
  - the localparams for zero and one of width C_LEN_WIDTH.
- Sub-module `rtc_gen_down_counter` is the remaining-beat counter:
  - a load/decrement counter with an `is_one` flag output (used to drive TLAST);
  - asynchronous active-low reset;
  - instantiated once.
- The stats counters, when enabled, are plain inline registers.

## Test plan
- Reset, then `cmd_len`=4, `cmd_start`=0x10, `tready`=1 → beats 0x10, 0x11, 0x12, 0x13 on 4 consecutive cycles, `tlast` only on 0x13, `done` the next cycle, `cmd_ready` the cycle after.
- `cmd_len`=0 → no `tvalid` ever, `done` 1 cycle after accept, `cmd_ready` back 2 cycles after accept.
- `cmd_len`=3, `cmd_start`=0xFFFF_FFFF, `tready` toggling 1,0,0,1,0,1 → data 0xFFFF_FFFF, 0x0, 0x1 in order, outputs stable during stalls, exactly 3 transfers.
- `cmd_valid` held high throughout with `cmd_len`=2 → second command accepted only after `done`, giving back-to-back bursts with a 2-cycle gap.
- `ap_rst_n` asserted after 2 of 5 beats → `tvalid`, `tlast` and `done` go to 0 immediately with no TLAST emitted, and a new `cmd_len`=1 burst works after release.
- With `RTC_GEN_BURST_TX_STATS_EN` defined, bursts of lengths 4, 0 and 3 → `stat_beats`=7, `stat_bursts`=3.
